// File: rtl/serial_pkt_pkg.sv
// Shared types and constants for the serial packet receiver.
// Holds the frame-FSM state encoding, the fixed-width packet status struct,
// the error-bit positions inside pkt_err, and the CRC-4 polynomial used
// when SERIAL_PACKET_RX_CRC_CHECK_EN is defined.
package serial_pkt_pkg;

    // Frame receiver states; the encoding is also exported on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TYPE    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_STOP    = 2'd3
    } frame_state_e;

    // Data-frame counter width and its saturation value.
    localparam int          COUNT_W   = 5;
    localparam logic [4:0]  COUNT_MAX = 5'd31;

    // Bit positions inside pkt_err = {frame_err, count_err, crc_err}.
    localparam int ERR_FRAME_BIT = 2;
    localparam int ERR_COUNT_BIT = 1;
    localparam int ERR_CRC_BIT   = 0;

    // x^4 + x + 1 with the implicit x^4 term dropped.
    localparam logic [3:0] CRC4_POLY = 4'h3;

    // Fixed-width tail of every buffered packet: frame count and error flags.
    // The payload and control fields depend on module parameters and are
    // concatenated in front of this struct by the top level.
    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic [2:0]         err;
    } pkt_status_t;

    // One MSB-first step of the CRC-4 shift register (init 0, no final xor).
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
        logic fb;
        fb        = crc[3] ^ din;
        crc4_step = {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
    endfunction

endpackage

// File: rtl/serial_packet_fifo.sv
// Completed-packet buffer for serial_packet_rx.
// Plain synchronous FIFO with an extra wrap bit on each pointer. A push on a
// full FIFO is accepted only when a pop happens in the same cycle; the pop
// frees the slot first, so the new entry lands where the old head was.
module serial_packet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status flags, accepted transfers and next pointer values.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/serial_packet_rx.sv
// Serial packet receiver.
// Receives frames {start 0, type, DATA_W payload bits MSB first, stop 1} on
// sin, gathers NUM_DATA data frames plus one control frame into a packet and
// buffers completed packets in serial_packet_fifo for a valid/ready consumer.
// Optional feature: define SERIAL_PACKET_RX_CRC_CHECK_EN to build the CRC-4
// check of pkt_data and pkt_ctl[DATA_W-1:4] against pkt_ctl[3:0]; without it
// crc_err is always 0. The CRC build needs DATA_W >= 5.
//
// Handshake: the head packet moves out at a posedge where pkt_valid and
// pkt_ready are both high; pkt_valid never waits on pkt_ready, and all pkt_*
// outputs hold steady while pkt_valid is high and pkt_ready is low.
//
// Packet pipeline: the control frame's stop-bit edge marks completion
// (done_q), the next edge snapshots the packet into a staging register and
// clears the accumulator, and the edge after that writes the FIFO, so
// pkt_valid rises two cycles after the stop bit when the FIFO was empty.
// A frame with a bad stop bit is still used as a normal frame; it only marks
// the packet with frame_err.
module serial_packet_rx
    import serial_pkt_pkg::*;
#(
    parameter int NUM_DATA   = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sin,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic [NUM_DATA*DATA_W-1:0] pkt_data,
    output logic [DATA_W-1:0]          pkt_ctl,
    output logic [4:0]                 pkt_count,
    output logic [2:0]                 pkt_err,
    output logic                       overrun,
    output logic [1:0]                 dbg_state
);

    localparam int PKT_W     = NUM_DATA * DATA_W;
    localparam int ST_W      = $bits(pkt_status_t);
    localparam int ENTRY_W   = PKT_W + DATA_W + ST_W;
    localparam int BIT_CNT_W = $clog2(DATA_W + 1);

    frame_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   is_ctl_q, is_ctl_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [PKT_W-1:0]       data_q, data_d;
    logic [DATA_W-1:0]      ctl_q, ctl_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   count_err_q, count_err_d;
    logic                   done_q, done_d;
    logic                   stage_vld_q, stage_vld_d;
    logic [ENTRY_W-1:0]     stage_q, stage_d;
    logic                   overrun_q, overrun_d;

    logic                   last_bit;
    logic                   load_type;
    logic                   shift_bit;
    logic                   frame_end;
    logic                   crc_err;
    pkt_status_t            stage_status;
    pkt_status_t            head_status;
    logic [ENTRY_W-1:0]     fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    assign last_bit = (state_q == ST_PAYLOAD) &&
                      (bit_cnt_q == BIT_CNT_W'(DATA_W - 1));

    // Frame FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state: one cycle each for type and stop, DATA_W for payload.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!sin) state_d = ST_TYPE;
            ST_TYPE:    state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (last_bit) state_d = ST_STOP;
            ST_STOP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Frame FSM outputs: per-state strobes for the datapath.
    always_comb begin
        load_type = 1'b0;
        shift_bit = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            ST_TYPE:    load_type = 1'b1;
            ST_PAYLOAD: shift_bit = 1'b1;
            ST_STOP:    frame_end = 1'b1;
            default:    ;
        endcase
    end

    assign dbg_state = state_q;

`ifdef SERIAL_PACKET_RX_CRC_CHECK_EN
    logic [3:0] crc_calc;

    // CRC-4 over the accumulated payload followed by the upper control bits.
    always_comb begin
        crc_calc = 4'h0;
        for (int i = PKT_W - 1; i >= 0; i--) begin
            crc_calc = crc4_step(crc_calc, data_q[i]);
        end
        for (int i = DATA_W - 1; i >= 4; i--) begin
            crc_calc = crc4_step(crc_calc, ctl_q[i]);
        end
        crc_err = (crc_calc != ctl_q[3:0]);
    end
`else
    assign crc_err = 1'b0;
`endif

    // Count and error flags of the packet being snapshotted.
    always_comb begin
        stage_status                    = '0;
        stage_status.count              = count_q;
        stage_status.err[ERR_FRAME_BIT] = frame_err_q;
        stage_status.err[ERR_COUNT_BIT] = count_err_q;
        stage_status.err[ERR_CRC_BIT]   = crc_err;
    end

    // Frame assembly, packet accumulation, snapshot and overrun tracking.
    always_comb begin
        is_ctl_d    = is_ctl_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        ctl_d       = ctl_q;
        count_d     = count_q;
        frame_err_d = frame_err_q;
        count_err_d = count_err_q;
        done_d      = 1'b0;
        stage_vld_d = 1'b0;
        stage_d     = stage_q;
        overrun_d   = overrun_q | (stage_vld_q & fifo_full & ~fifo_pop);

        if (load_type) begin
            is_ctl_d  = sin;
            bit_cnt_d = '0;
        end

        if (shift_bit) begin
            shreg_d   = DATA_W'({shreg_q, sin});
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end

        // Snapshot the finished packet, then start a fresh one.
        if (done_q) begin
            stage_vld_d = 1'b1;
            stage_d     = {data_q, ctl_q, stage_status};
            data_d      = '0;
            ctl_d       = '0;
            count_d     = '0;
            frame_err_d = 1'b0;
            count_err_d = 1'b0;
        end

        if (frame_end) begin
            if (!sin) begin
                frame_err_d = 1'b1;
            end
            if (is_ctl_q) begin
                ctl_d  = shreg_q;
                done_d = 1'b1;
                if (count_q != COUNT_W'(NUM_DATA)) begin
                    count_err_d = 1'b1;
                end
            end else begin
                // Frame k lands in slot k counted from the MSB end.
                if (count_q < COUNT_W'(NUM_DATA)) begin
                    for (int k = 0; k < NUM_DATA; k++) begin
                        if (count_q == COUNT_W'(k)) begin
                            data_d[(NUM_DATA-1-k)*DATA_W +: DATA_W] = shreg_q;
                        end
                    end
                end else begin
                    count_err_d = 1'b1;
                end
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + COUNT_W'(1);
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q   <= '0;
            is_ctl_q    <= 1'b0;
            shreg_q     <= '0;
            data_q      <= '0;
            ctl_q       <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            count_err_q <= 1'b0;
            done_q      <= 1'b0;
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            is_ctl_q    <= is_ctl_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            ctl_q       <= ctl_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            count_err_q <= count_err_d;
            done_q      <= done_d;
            stage_vld_q <= stage_vld_d;
            stage_q     <= stage_d;
            overrun_q   <= overrun_d;
        end
    end

    assign fifo_pop = pkt_valid & pkt_ready;

    serial_packet_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (stage_vld_q),
        .push_data (stage_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {pkt_data, pkt_ctl, head_status} = fifo_rdata;
    assign pkt_count = head_status.count;
    assign pkt_err   = head_status.err;
    assign pkt_valid = ~fifo_empty;
    assign overrun   = overrun_q;

endmodule
